tl_ul_sram_responder: RTL and testbench
=======================================

Name: tl_ul_sram_responder

Overview:
- TileLink-UL manager (responder) backed by an internal word-addressed register array; it is the manager-side counterpart of the channel A/D traffic the TL monitors check.
- Accepts single-beat Get, PutFullData and PutPartialData on channel A and returns AccessAckData or AccessAck on channel D.
- A small response queue absorbs D-channel backpressure.
- Serves as the testbench and eval-platform slave behind a TL-UL crossbar port.

Parameters:
- ADDR_W, 25, channel A address width
- DATA_W, 32, beat width; mask width is DATA_W/8
- SOURCE_W, 7, source ID width
- MEM_WORDS, 1024, array depth in DATA_W words (power of 2)
- BASE_ADDR, 0, byte address of word 0 (aligned to MEM_WORDS*DATA_W/8)
- QUEUE_DEPTH, 2, response queue entries (>=1)

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous assert, active-low reset
- a_valid  in  1  channel A valid
- a_ready  out  1  channel A ready
- a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get
- a_param  in  3  ignored
- a_size  in  3  log2 bytes
- a_source  in  SOURCE_W  request ID
- a_address  in  ADDR_W  byte address
- a_mask  in  DATA_W/8  byte lanes
- a_data  in  DATA_W  write data
- a_corrupt  in  1  write data poisoned
- d_valid  out  1  channel D valid
- d_ready  in  1  channel D ready
- d_opcode  out  3  0=AccessAck, 1=AccessAckData
- d_param  out  2  always 0
- d_size  out  3  echo of a_size
- d_source  out  SOURCE_W  echo of a_source
- d_sink  out  1  always 0
- d_denied  out  1  request rejected
- d_data  out  DATA_W  read data
- d_corrupt  out  1  data invalid

Behaviour:
- Reset (reset_n low, async): queue emptied. a_ready=0 while reset is held, then 1. d_valid=0; all d_* fields read 0. Array contents are not reset.
- a_ready = queue count < QUEUE_DEPTH. It is purely registered state and never depends on a_valid.
- Accept = a_valid & a_ready. At most one accept per cycle.
- Denied when any of the following holds:
  - opcode not in {0,1,4}
  - a_size > log2(DATA_W/8)
  - a_address not aligned to 2^a_size
  - a_address outside [BASE_ADDR, BASE_ADDR + MEM_WORDS*DATA_W/8)
- Word index = (a_address - BASE_ADDR) >> log2(DATA_W/8).
- Put (not denied, a_corrupt=0): at the accept edge, write the bytes enabled by a_mask. Lanes outside the size/offset window are not masked off by the block; the requester owns mask legality.
- Put with a_corrupt=1: array unchanged. Response is AccessAck with denied=0.
- Get (not denied): the full word is read at the accept edge and enqueued. d_data carries the full word regardless of mask.
- Denied Get: d_data=0, d_denied=1, d_corrupt=1. Denied Put: array unchanged, d_denied=1, d_corrupt=0.
- Latency: the response is enqueued at the accept edge, so d_valid rises the cycle after accept at the earliest.
- D-channel handshake:
  - d_* fields hold stable while d_valid & !d_ready.
  - Responses are strictly in acceptance order.
  - An entry dequeues on d_valid & d_ready.
- Full queue with a simultaneous dequeue: a_ready stays 0 that cycle; there is no combinational d_ready->a_ready path. The slot reopens the next cycle.
- Back-to-back: with d_ready held at 1, one accept and one response per cycle are sustained.
- Ordering and hazards:
  - A Get accepted the cycle after a Put to the same word returns the new data.
  - Queue pointers wrap modulo QUEUE_DEPTH. The count distinguishes full from empty.
- Reset mid-operation: queued responses are discarded and the array keeps its contents.

Decomposition:
- Shared package tl_ul_pkg holds:
  - A opcode constants (PUT_FULL=0, PUT_PARTIAL=1, GET=4)
  - D opcode constants (ACCESS_ACK=0, ACCESS_ACK_DATA=1)
  - a packed d_beat_t struct {opcode, size, source, denied, data, corrupt}
- One sub-module, tl_resp_queue: a parameterized synchronous FIFO of d_beat_t with ready/valid ports, async active-low reset and count-based full/empty.
- Decode, array and write logic stay in the top.

Test Plan:
- Reset sequence:
  - Stimulus: reset_n low 3 cycles, then released.
  - Required: d_valid=0 throughout; a_ready=0 during reset and 1 on the first cycle after release.
- PutFull then Get:
  - Stimulus: PutFull addr 0x10, mask 0xF, data 0xDEADBEEF, src 5; next cycle Get addr 0x10, src 6.
  - Required: D order AccessAck src 5, then AccessAckData src 6 with data 0xDEADBEEF, denied=0.
- PutPartial:
  - Stimulus: word 0x20 = 0x11223344; PutPartial mask 0x2, data 0x0000AA00; then Get 0x20.
  - Required: Get returns 0x1122AA44.
- Backpressure:
  - Stimulus: d_ready=0; three Gets presented.
  - Required: two are accepted, then a_ready=0; d_* stable for 10 cycles. After d_ready=1, responses drain in order and the third Get is accepted.
- Denial cases:
  - Get at 0x1000 (out of range for the default parameters, which map 0x0-0xFFF): response denied=1, corrupt=1, data=0.
  - Get size 3: response denied=1.
  - Put size 2 at addr 0x2 (misaligned): response denied=1, array unchanged.
  - Opcode 2: response denied=1.
- Corrupt put and mid-traffic reset:
  - Put with a_corrupt=1: AccessAck with denied=0, and a subsequent Get returns the old word.
  - reset_n pulsed with two responses queued: d_valid=0 immediately, and the array is preserved.

Source files
------------

// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL encodings and the D-channel beat carried through the response queue.
package tl_ul_pkg;

  localparam int TL_DATA_W   = 32;
  localparam int TL_SOURCE_W = 7;

  // Channel A opcodes
  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;

  // Channel D opcodes
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [2:0]             size;
    logic [TL_SOURCE_W-1:0] source;
    logic                   denied;
    logic [TL_DATA_W-1:0]   data;
    logic                   corrupt;
  } d_beat_t;

endpackage

// File: rtl/tl_resp_queue.sv
// Synchronous FIFO of D-channel beats; full/empty come from an occupancy count so pointers may wrap freely.
module tl_resp_queue
  import tl_ul_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clock,
  input  logic    reset_n,
  input  logic    in_valid,
  output logic    in_ready,
  input  d_beat_t in_beat,
  output logic    out_valid,
  input  logic    out_ready,
  output d_beat_t out_beat
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  d_beat_t            slots [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push, pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // Empty slots present zeros so the D fields read 0 whenever d_valid is low.
  assign out_beat  = out_valid ? slots[rd_ptr] : '0;

  // NOTE: storage has no reset; only the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push) slots[wr_ptr] <= in_beat;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL manager backed by a word-addressed register array; single-beat Get/Put with queued D responses.
module tl_ul_sram_responder
  import tl_ul_pkg::*;
#(
  parameter int                ADDR_W      = 25,
  parameter int                DATA_W      = TL_DATA_W,
  parameter int                SOURCE_W    = TL_SOURCE_W,
  parameter int                MEM_WORDS   = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                QUEUE_DEPTH = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [2:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W/8-1:0] a_mask,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                a_corrupt,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [2:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_sink,
  output logic                d_denied,
  output logic [DATA_W-1:0]   d_data,
  output logic                d_corrupt
);

  localparam int MASK_W  = DATA_W / 8;
  localparam int OFF_W   = $clog2(MASK_W);
  localparam int WORD_AW = $clog2(MEM_WORDS);
  localparam int BYTE_AW = WORD_AW + OFF_W;

  logic                 rst_done, q_in_ready, accept;
  logic                 is_get, is_put, denied, wr_en;
  logic [WORD_AW-1:0]   word_idx;
  logic [DATA_W-1:0]    mem [MEM_WORDS];
  d_beat_t              req_beat, d_beat;
  logic                 unused_param;

  assign unused_param = ^a_param;

  // Holds a_ready low while reset is asserted; rises on the first edge after release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_done <= 1'b0;
    else          rst_done <= 1'b1;
  end

  assign a_ready = rst_done & q_in_ready;
  assign accept  = a_valid & a_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    is_get   = (a_opcode == GET);
    is_put   = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);
    word_idx = a_address[BYTE_AW-1:OFF_W];
    // BASE_ADDR is window-aligned, so range membership is an upper-bit compare.
    denied   = !(is_get || is_put)
             || (a_size > 3'(OFF_W))
             || (|(a_address & ~({ADDR_W{1'b1}} << a_size)))
             || (a_address[ADDR_W-1:BYTE_AW] != BASE_ADDR[ADDR_W-1:BYTE_AW]);
    wr_en    = accept && is_put && !denied && !a_corrupt;
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (a_mask[b]) mem[word_idx][b*8 +: 8] <= a_data[b*8 +: 8];
      end
    end
  end

  // The read happens before this edge's write, so a Get sees the previous cycle's Put.
  always_comb begin
    req_beat         = '0;
    req_beat.opcode  = is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
    req_beat.size    = a_size;
    req_beat.source  = a_source;
    req_beat.denied  = denied;
    req_beat.data    = (is_get && !denied) ? mem[word_idx] : '0;
    req_beat.corrupt = is_get && denied;
  end

  tl_resp_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_resp_queue (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (accept),
    .in_ready (q_in_ready),
    .in_beat  (req_beat),
    .out_valid(d_valid),
    .out_ready(d_ready),
    .out_beat (d_beat)
  );

  assign d_opcode  = d_beat.opcode;
  assign d_param   = '0;
  assign d_size    = d_beat.size;
  assign d_source  = d_beat.source;
  assign d_sink    = 1'b0;
  assign d_denied  = d_beat.denied;
  assign d_data    = d_beat.data;
  assign d_corrupt = d_beat.corrupt;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Scoreboard bench for tl_ul_sram_responder: predicted D beats are queued on accept and compared on dequeue.
module tb_tl_ul_sram_responder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [6:0]  a_source;
  logic [24:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        a_corrupt;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode, d_size;
  logic [1:0]  d_param;
  logic [6:0]  d_source;
  logic        d_sink, d_denied, d_corrupt;
  logic [31:0] d_data;

  typedef struct {
    logic [2:0]  opcode;
    logic [2:0]  size;
    logic [6:0]  source;
    logic        denied;
    logic [31:0] data;
    logic        corrupt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [1024];
  int          vectors = 0;
  int          miscompares = 0;
  int          stall_cycles = 0;
  bit          rand_done;

  always #5 clock = ~clock;

  tl_ul_sram_responder dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .a_corrupt(a_corrupt),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
    .d_data(d_data), .d_corrupt(d_corrupt)
  );

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Independent reference: 4 KiB window at 0, 4-byte words.
  function automatic exp_t predict(input logic [2:0] op, input logic [2:0] size,
                                   input logic [24:0] addr, input logic [6:0] src);
    exp_t        e;
    int unsigned a = int'(addr);
    bit          den;
    den = !(op == 3'd0 || op == 3'd1 || op == 3'd4) || (size > 3'd2)
        || ((a % (32'd1 << size)) != 0) || (a >= 32'd4096);
    e.opcode  = (op == 3'd4) ? 3'd1 : 3'd0;
    e.size    = size;
    e.source  = src;
    e.denied  = den;
    e.data    = (op == 3'd4 && !den) ? model[a / 4] : 32'd0;
    e.corrupt = (op == 3'd4) && den;
    return e;
  endfunction

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic send(input logic [2:0] op, input logic [2:0] size, input logic [24:0] addr,
                      input logic [3:0] mask, input logic [31:0] data, input logic corrupt,
                      input logic [6:0] src);
    int   waited = 0;
    exp_t e;
    a_valid = 1'b1; a_opcode = op; a_size = size; a_address = addr;
    a_mask = mask; a_data = data; a_corrupt = corrupt; a_source = src;
    a_param = 3'($urandom_range(0, 7));
    #1;
    while (!a_ready) begin
      if (waited == 100) begin
        check("a_ready_timeout", 1'b0, 1'b1);
        a_valid = 1'b0;
        return;
      end
      @(negedge clock); #1;
      waited++;
    end
    stall_cycles += waited;
    e = predict(op, size, addr, src);
    sb.push_back(e);
    if ((op == 3'd0 || op == 3'd1) && !e.denied && !corrupt) begin
      for (int b = 0; b < 4; b++)
        if (mask[b]) model[int'(addr) / 4][b*8 +: 8] = data[b*8 +: 8];
    end
    @(negedge clock);
    a_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    check("drain_empty", sb.size(), 0);
  endtask

  // Response monitor: sample mid-low-phase, compare against the scoreboard head on each handshake.
  initial begin
    forever begin
      @(negedge clock); #2;
      if (reset_n && d_valid && d_ready) begin
        if (sb.size() == 0) check("unexpected_d", 1'b1, 1'b0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("d_opcode",  d_opcode,  e.opcode);
          check("d_source",  d_source,  e.source);
          check("d_size",    d_size,    e.size);
          check("d_denied",  d_denied,  e.denied);
          check("d_data",    d_data,    e.data);
          check("d_corrupt", d_corrupt, e.corrupt);
          check("d_param_sink", {d_param, d_sink}, 3'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap_data;
    logic [6:0]  snap_src;
    logic [2:0]  snap_op;

    reset_n = 1'b0; a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0;
    a_source = '0; a_address = '0; a_mask = '0; a_data = '0; a_corrupt = 1'b0;
    d_ready = 1'b1;

    // Reset sequence
    repeat (3) begin
      @(negedge clock);
      check("rst_d_valid", d_valid, 1'b0);
      check("rst_a_ready", a_ready, 1'b0);
    end
    reset_n = 1'b1;
    @(negedge clock);
    check("a_ready_after_rst", a_ready, 1'b1);
    check("d_valid_after_rst", d_valid, 1'b0);

    // PutFull then Get, PutPartial merge
    send(3'd0, 3'd2, 25'h10, 4'hF, 32'hDEADBEEF, 1'b0, 7'd5);
    send(3'd4, 3'd2, 25'h10, 4'hF, 32'h0, 1'b0, 7'd6);
    send(3'd0, 3'd2, 25'h20, 4'hF, 32'h11223344, 1'b0, 7'd1);
    send(3'd1, 3'd2, 25'h20, 4'h2, 32'h0000AA00, 1'b0, 7'd2);
    send(3'd4, 3'd2, 25'h20, 4'hF, 32'h0, 1'b0, 7'd3);
    drain();

    // Backpressure: two Gets fill the queue, the third waits
    d_ready = 1'b0;
    fork
      begin
        send(3'd4, 3'd2, 25'h10, 4'hF, 32'h0, 1'b0, 7'd21);
        send(3'd4, 3'd2, 25'h20, 4'hF, 32'h0, 1'b0, 7'd22);
        send(3'd4, 3'd2, 25'h10, 4'hF, 32'h0, 1'b0, 7'd23);
      end
      begin
        repeat (3) @(negedge clock);
        #2;
        check("bp_a_ready_low", a_ready, 1'b0);
        check("bp_head_src", d_source, 7'd21);
        snap_data = d_data; snap_src = d_source; snap_op = d_opcode;
        for (int i = 0; i < 10; i++) begin
          @(negedge clock); #2;
          check("bp_hold_valid", d_valid, 1'b1);
          check("bp_hold", {d_opcode, d_source, d_data}, {snap_op, snap_src, snap_data});
          check("bp_a_ready_low", a_ready, 1'b0);
        end
        @(negedge clock);
        d_ready = 1'b1;
      end
    join
    drain();

    // Denials
    send(3'd0, 3'd2, 25'h0, 4'hF, 32'hCAFEF00D, 1'b0, 7'd9);
    send(3'd4, 3'd2, 25'h1000, 4'hF, 32'h0, 1'b0, 7'd10);
    send(3'd4, 3'd3, 25'h0, 4'hF, 32'h0, 1'b0, 7'd11);
    send(3'd0, 3'd2, 25'h2, 4'hF, 32'h55555555, 1'b0, 7'd12);
    send(3'd2, 3'd2, 25'h0, 4'hF, 32'h0, 1'b0, 7'd13);
    send(3'd4, 3'd2, 25'h0, 4'hF, 32'h0, 1'b0, 7'd14);
    // Corrupt put leaves the word alone
    send(3'd0, 3'd2, 25'h0, 4'hF, 32'h12345678, 1'b1, 7'd15);
    send(3'd4, 3'd2, 25'h0, 4'hF, 32'h0, 1'b0, 7'd16);
    drain();

    // Back-to-back burst with d_ready held high: no stalls expected
    stall_cycles = 0;
    for (int i = 0; i < 8; i++)
      send(3'd0, 3'd2, 25'(32'h200 + 4 * i), 4'hF, $urandom, 1'b0, 7'(i));
    for (int i = 0; i < 8; i++)
      send(3'd4, 3'd2, 25'(32'h200 + 4 * i), 4'hF, 32'h0, 1'b0, 7'(i + 8));
    check("burst_stalls", stall_cycles, 0);
    drain();

    // Random mix with random D backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [2:0] op;
          case ($urandom_range(0, 2))
            0:       op = 3'd0;
            1:       op = 3'd1;
            default: op = 3'd4;
          endcase
          send(op, 3'd2, 25'(32'h200 + 4 * $urandom_range(0, 7)), 4'($urandom_range(0, 15)),
               $urandom, 1'($urandom_range(0, 3) == 0), 7'($urandom_range(0, 127)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clock);
          d_ready = 1'($urandom_range(0, 1));
        end
        d_ready = 1'b1;
      end
    join
    drain();

    // Reset with two responses queued
    d_ready = 1'b0;
    send(3'd4, 3'd2, 25'h200, 4'hF, 32'h0, 1'b0, 7'd30);
    send(3'd4, 3'd2, 25'h204, 4'hF, 32'h0, 1'b0, 7'd31);
    check("mid_q_valid", d_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_d_valid", d_valid, 1'b0);
    check("mid_rst_a_ready", a_ready, 1'b0);
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    d_ready = 1'b1;
    @(negedge clock);
    send(3'd4, 3'd2, 25'h10, 4'hF, 32'h0, 1'b0, 7'd32);
    send(3'd4, 3'd2, 25'h0, 4'hF, 32'h0, 1'b0, 7'd33);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
